viexo_pattern: RTL and testbench

Video test-pattern source for the HDMI transmit path. It sits directly upstream of the three TMDS channel encoders and downstream of the `viexo_paint` timing generator. It consumes the raw hblank/vblank/hsync/vsync strobes, tracks pixel position, and emits 8-bit R/G/B with data-enable and sync outputs. All outputs are delay-matched so they can feed the encoders' `d`, `de` and `c` inputs directly.

---
 rtl/viexo_pattern_if.sv | 32 +++
 rtl/viexo_pattern.sv | 138 +++++++++++++
 tb/tb_viexo_pattern.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/viexo_pattern_if.sv
// Pixel-stream bundle between the timing generator, the pattern source and the TMDS encoders.
// The stream has no handshake. One pixel moves per aclk, de marks the active pixels, and the sink must always accept.
interface viexo_pattern_if;
    logic       hblank;
    logic       vblank;
    logic       hsync;
    logic       vsync;
    logic [1:0] pattern_sel;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de;
    logic       hsync_o;
    logic       vsync_o;
    logic [7:0] frame;
    logic [10:0] dbg_x;
    logic [9:0]  dbg_y;
    logic [1:0]  dbg_pat;
    logic        dbg_last_line;

    modport master (
        output hblank, vblank, hsync, vsync, pattern_sel,
        input  r, g, b, de, hsync_o, vsync_o, frame,
        input  dbg_x, dbg_y, dbg_pat, dbg_last_line
    );

    modport slave (
        input  hblank, vblank, hsync, vsync, pattern_sel,
        output r, g, b, de, hsync_o, vsync_o, frame,
        output dbg_x, dbg_y, dbg_pat, dbg_last_line
    );
endinterface

// File: rtl/viexo_pattern.sv
// Two-stage video test-pattern source: stage 1 tracks position and frame, stage 2 registers colour and syncs.
module viexo_pattern #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter logic [23:0] SOLID_RGB = 24'h202020
) (
    input  logic           aclk,
    input  logic           areset,
    viexo_pattern_if.slave vid
);
    localparam int BARS  = H_ACTIVE / 8;
    localparam int BAR_W = (BARS > 1) ? $clog2(BARS) : 1;
    localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BARS - 1);

    // Stage 1
    logic             de1_q, de1_d;
    logic             hsync1_q, hsync1_d;
    logic             vsync1_q, vsync1_d;
    logic             vblank1_q, vblank1_d;
    logic [10:0]      x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [BAR_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [7:0]       frame_q, frame_d;
    logic [1:0]       pat_q, pat_d;
    // Stage 2
    logic             de_q, de_d;
    logic             hsync_o_q, hsync_o_d;
    logic             vsync_o_q, vsync_o_d;
    logic [23:0]      rgb_q, rgb_d;
    logic [7:0]       frame_o_q, frame_o_d;

    logic       de_in;
    logic       frame_start;
    logic       run;
    logic [7:0] grad_r;
    logic [23:0] pixel;

    always_comb begin
        de_in       = ~(vid.hblank | vid.vblank);
        frame_start = vid.vblank & ~vblank1_q;
        // x and the bar tracker belong to the pixel being registered; the first active pixel restarts them.
        run         = de_in & de1_q;

        de1_d     = de_in;
        hsync1_d  = vid.hsync;
        vsync1_d  = vid.vsync;
        vblank1_d = vid.vblank;

        x_d       = run ? x_q + 11'd1 : 11'd0;
        bar_cnt_d = '0;
        bar_idx_d = 3'd0;
        if (run) begin
            bar_idx_d = bar_idx_q;
            if (bar_cnt_q == BAR_LAST) begin
                if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
        end

        // Clearing in vblank wins over the end-of-line increment.
        if (vid.vblank) begin
            y_d = 10'd0;
        end else if (de1_q & ~de_in) begin
            y_d = y_q + 10'd1;
        end else begin
            y_d = y_q;
        end

        frame_d = frame_start ? frame_q + 8'd1 : frame_q;
        pat_d   = frame_start ? vid.pattern_sel : pat_q;

        grad_r = x_q[7:0] + frame_q;
        unique case (pat_q)
            2'd0:    pixel = SOLID_RGB;
            2'd1:    pixel = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
            2'd2:    pixel = {24{x_q[5] ^ y_q[5]}};
            default: pixel = {grad_r, y_q[7:0], frame_q};
        endcase

        de_d      = de1_q;
        hsync_o_d = hsync1_q;
        vsync_o_d = vsync1_q;
        rgb_d     = de1_q ? pixel : 24'h000000;
        frame_o_d = frame_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            de1_q     <= 1'b0;
            hsync1_q  <= 1'b0;
            vsync1_q  <= 1'b0;
            vblank1_q <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            frame_q   <= '0;
            pat_q     <= '0;
            de_q      <= 1'b0;
            hsync_o_q <= 1'b0;
            vsync_o_q <= 1'b0;
            rgb_q     <= '0;
            frame_o_q <= '0;
        end else begin
            de1_q     <= de1_d;
            hsync1_q  <= hsync1_d;
            vsync1_q  <= vsync1_d;
            vblank1_q <= vblank1_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            frame_q   <= frame_d;
            pat_q     <= pat_d;
            de_q      <= de_d;
            hsync_o_q <= hsync_o_d;
            vsync_o_q <= vsync_o_d;
            rgb_q     <= rgb_d;
            frame_o_q <= frame_o_d;
        end
    end

    assign vid.r             = rgb_q[23:16];
    assign vid.g             = rgb_q[15:8];
    assign vid.b             = rgb_q[7:0];
    assign vid.de            = de_q;
    assign vid.hsync_o       = hsync_o_q;
    assign vid.vsync_o       = vsync_o_q;
    assign vid.frame         = frame_o_q;
    assign vid.dbg_x         = x_q;
    assign vid.dbg_y         = y_q;
    assign vid.dbg_pat       = pat_q;
    assign vid.dbg_last_line = (y_q == 10'(V_ACTIVE - 1));
endmodule

// File: tb/tb_viexo_pattern.sv
// Directed bench for viexo_pattern: reset, all four patterns, frame counting and sync alignment.
module tb_viexo_pattern;
  logic aclk = 1'b0;
  logic areset;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_frame;
  logic [7:0] cap_r[0:2047];
  logic [7:0] cap_g[0:2047];
  logic [7:0] cap_b[0:2047];
  logic       cap_de[0:2047];
  logic [15:0] hs_vec;
  logic [15:0] vs_vec;
  int de_cnt;

  viexo_pattern_if vid();

  viexo_pattern #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .SOLID_RGB(24'h202020)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .vid(vid)
  );

  // clock
  always #5 aclk = ~aclk;

  // driver tasks
  task automatic tick(input logic hb, input logic vb);
    vid.hblank = hb;
    vid.vblank = vb;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int idx, input logic exp_de, input logic [23:0] exp_rgb);
    chk(tag, {7'd0, cap_de[idx], cap_r[idx], cap_g[idx], cap_b[idx]}, {7'd0, exp_de, exp_rgb});
  endtask

  task automatic out_now(input string tag, input logic exp_de, input logic [23:0] exp_rgb);
    chk(tag, {7'd0, vid.de, vid.r, vid.g, vid.b}, {7'd0, exp_de, exp_rgb});
  endtask

  // One line: n_act active pixels then n_blk blanking; output after tick i is pixel x=i-1.
  task automatic drive_line(input int n_act, input int n_blk);
    de_cnt = 0;
    for (int i = 0; i < n_act + n_blk; i++) begin
      tick(i >= n_act, 1'b0);
      cap_de[i] = vid.de;
      cap_r[i]  = vid.r;
      cap_g[i]  = vid.g;
      cap_b[i]  = vid.b;
      if (vid.de === 1'b1) de_cnt++;
    end
  endtask

  task automatic frame_start(input logic [1:0] sel);
    vid.pattern_sel = sel;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    exp_frame = exp_frame + 8'd1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    areset = 1'b0;
    exp_frame = 8'd0;
  endtask

  initial begin
    vid.hblank = 1'b1;
    vid.vblank = 1'b1;
    vid.hsync = 1'b1;
    vid.vsync = 1'b1;
    vid.pattern_sel = 2'd0;
    exp_frame = 8'd0;
    hs_vec = 16'b1011_0011_1010_0110;
    vs_vec = 16'b0110_1110_0001_1011;

    // reset state, sync inputs held high
    do_reset();
    out_now("reset_pix", 1'b0, 24'h000000);
    chk("reset_sync", {30'd0, vid.hsync_o, vid.vsync_o}, 32'd0);
    chk("reset_frame", {24'd0, vid.frame}, 32'd0);

    // reset asserted mid-line
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    out_now("pre_rst_pix", 1'b1, 24'h202020);
    chk("pre_rst_hsync", {31'd0, vid.hsync_o}, 32'd1);
    areset = 1'b1;
    tick(1'b0, 1'b0);
    out_now("midrst_pix", 1'b0, 24'h000000);
    chk("midrst_sync", {30'd0, vid.hsync_o, vid.vsync_o}, 32'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    areset = 1'b0;
    vid.hsync = 1'b0;
    vid.vsync = 1'b0;
    tick(1'b0, 1'b0);
    out_now("rel_first", 1'b0, 24'h000000);
    tick(1'b0, 1'b0);
    out_now("rel_second", 1'b1, 24'h202020);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);

    // colour bars, 640-pixel line
    frame_start(2'd1);
    chk("frame_after_p1", {24'd0, vid.frame}, {24'd0, exp_frame});
    drive_line(640, 8);
    pix("bar_lead_blank", 0, 1'b0, 24'h000000);
    pix("bar_x0", 1, 1'b1, 24'hFFFFFF);
    pix("bar_x79", 80, 1'b1, 24'hFFFFFF);
    pix("bar_x80", 81, 1'b1, 24'hFFFF00);
    pix("bar_x559", 560, 1'b1, 24'h0000FF);
    pix("bar_x560", 561, 1'b1, 24'h000000);
    pix("bar_x639", 640, 1'b1, 24'h000000);
    pix("bar_blank", 641, 1'b0, 24'h000000);
    chk("bar_de_count", de_cnt, 32'd640);
    drive_line(700, 4);
    pix("bar_sat_x689", 690, 1'b1, 24'h000000);
    pix("bar_x240", 241, 1'b1, 24'h00FF00);
    chk("long_de_count", de_cnt, 32'd700);

    // pattern_sel change mid-frame
    frame_start(2'd0);
    drive_line(64, 4);
    pix("solid_x0", 1, 1'b1, 24'h202020);
    pix("solid_blank", 65, 1'b0, 24'h000000);
    vid.pattern_sel = 2'd2;
    drive_line(64, 4);
    pix("midframe_sel", 40, 1'b1, 24'h202020);

    // checkerboard from line 0 of the next frame
    frame_start(2'd2);
    drive_line(64, 4);
    pix("chk_x0_y0", 1, 1'b1, 24'h000000);
    pix("chk_x32_y0", 33, 1'b1, 24'hFFFFFF);
    pix("chk_blank", 65, 1'b0, 24'h000000);
    for (int y = 1; y < 32; y++) drive_line(64, 4);
    drive_line(64, 4);
    pix("chk_x32_y32", 33, 1'b1, 24'h000000);
    pix("chk_x31_y32", 32, 1'b1, 24'hFFFFFF);

    // vblank rises on the same edge that ends the last line
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    exp_frame = exp_frame + 8'd1;
    chk("coincident_frame", {24'd0, vid.frame}, {24'd0, exp_frame});
    drive_line(64, 4);
    pix("coincident_y0", 33, 1'b1, 24'hFFFFFF);

    // scrolling gradient after 5 frame starts from reset
    do_reset();
    for (int f = 0; f < 5; f++) frame_start(2'd3);
    chk("frame5", {24'd0, vid.frame}, 32'd5);
    drive_line(16, 4);
    pix("grad_x0_y0", 1, 1'b1, 24'h050005);
    pix("grad_blank", 17, 1'b0, 24'h000000);
    drive_line(16, 4);
    drive_line(16, 4);
    drive_line(16, 4);
    pix("grad_x10_y3", 11, 1'b1, 24'h0F0305);

    // sync pass-through with arbitrary polarity during blanking
    vid.hsync = hs_vec[0];
    vid.vsync = vs_vec[0];
    tick(1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      vid.hsync = hs_vec[i];
      vid.vsync = vs_vec[i];
      tick(1'b1, 1'b0);
      chk("sync_align", {30'd0, vid.hsync_o, vid.vsync_o}, {30'd0, hs_vec[i-1], vs_vec[i-1]});
      chk("sync_blank_pix", {7'd0, vid.de, vid.r, vid.g, vid.b}, 32'd0);
    end
    vid.hsync = 1'b0;
    vid.vsync = 1'b0;

    // frame counter wrap
    for (int f = 0; f < 250; f++) frame_start(2'd3);
    chk("frame255", {24'd0, vid.frame}, 32'd255);
    frame_start(2'd3);
    chk("frame_wrap", {24'd0, vid.frame}, 32'd0);
    chk("frame_wrap_model", {24'd0, vid.frame}, {24'd0, exp_frame});
    drive_line(16, 4);
    pix("grad_wrap_x2", 3, 1'b1, 24'h020000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
